// File: rtl/score_display_multi.sv
// Multi-digit score overlay: serial binary-to-BCD conversion with a single-cycle
// commit, numbers-ROM addressing and a pixel flag aligned to the ROM latency.
//
// state  | meaning
// IDLE   | waiting for score_stb
// CONV   | double-dabble shift, one bit per clk
// COMMIT | copy all BCD nibbles to the display registers
module score_display_multi #(
    parameter int DIGITS       = 4,
    parameter int SCORE_W      = 14,
    parameter int X0           = 336,
    parameter int Y0           = 320,
    parameter int SCALE_LOG2   = 0,
    parameter int BLANK_LZ     = 1,
    parameter int BLINK_FRAMES = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               playing,
    input  logic [SCORE_W-1:0] score,
    input  logic               score_stb,
    input  logic               frame_tick,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    output logic [7:0]         rom_row,
    output logic [3:0]         rom_col,
    input  logic               rom_data,
    output logic               score_on,
    output logic               busy
);

    localparam int BCD_W   = 4 * DIGITS;
    localparam int MAX_VAL = 10 ** DIGITS - 1;
    localparam int CNT_W   = $clog2(SCORE_W + 1);
    localparam int BLK_W   = ($clog2(BLINK_FRAMES + 1) < 3) ? 3 : $clog2(BLINK_FRAMES + 1);
    localparam int CELL    = 16 << SCALE_LOG2;

    localparam bit                 SAT_EN  = (longint'(MAX_VAL) < (longint'(1) << SCORE_W));
    localparam logic [SCORE_W-1:0] SAT_VAL = SCORE_W'(MAX_VAL);

    localparam logic [10:0] X_LO = 11'(X0);
    localparam logic [10:0] X_HI = 11'(X0 + DIGITS * CELL);
    localparam logic [10:0] Y_LO = 11'(Y0);
    localparam logic [10:0] Y_HI = 11'(Y0 + CELL);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CONV   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    logic [1:0]         state;
    logic [SCORE_W-1:0] sh;
    logic [BCD_W-1:0]   bcd;
    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   disp;
    logic [CNT_W-1:0]   cnt;
    logic               pending;
    logic [SCORE_W-1:0] pend_score;
    logic [BLK_W-1:0]   blink;
    logic               commit_chg;
    logic               hide;

    function automatic logic [SCORE_W-1:0] sat(input logic [SCORE_W-1:0] v);
        return (SAT_EN && (v > SAT_VAL)) ? SAT_VAL : v;
    endfunction

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            sh         <= '0;
            bcd        <= '0;
            disp       <= '0;
            cnt        <= '0;
            pending    <= 1'b0;
            pend_score <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (score_stb) begin
                        sh    <= sat(score);
                        bcd   <= '0;
                        cnt   <= CNT_W'(SCORE_W);
                        state <= S_CONV;
                    end
                end
                S_CONV: begin
                    bcd <= {bcd_adj[BCD_W-2:0], sh[SCORE_W-1]};
                    sh  <= {sh[SCORE_W-2:0], 1'b0};
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1))
                        state <= S_COMMIT;
                    if (score_stb) begin
                        pending    <= 1'b1;
                        pend_score <= score;
                    end
                end
                S_COMMIT: begin
                    disp <= bcd;
                    // A strobe landing on the commit cycle is the newest value, so it wins over pending
                    if (score_stb || pending) begin
                        sh      <= sat(score_stb ? score : pend_score);
                        bcd     <= '0;
                        cnt     <= CNT_W'(SCORE_W);
                        pending <= 1'b0;
                        state   <= S_CONV;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy       = (state != S_IDLE);
    assign commit_chg = (state == S_COMMIT) && (bcd != disp);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            blink <= '0;
        else if (commit_chg && (BLINK_FRAMES != 0))
            blink <= BLK_W'(BLINK_FRAMES);
        else if (frame_tick && (blink != '0))
            blink <= blink - BLK_W'(1);
    end

    assign hide = (blink != '0) && blink[2];

    logic [10:0] xe, ye, dx, dy, k;
    logic        in_win;
    logic [3:0]  nib;
    logic [3:0]  dv;
    logic        lead;
    logic        blank;
    logic        visible;
    logic        visible_d1;

    assign xe     = {1'b0, x};
    assign ye     = {1'b0, y};
    assign dx     = xe - X_LO;
    assign dy     = ye - Y_LO;
    assign k      = dx >> (4 + SCALE_LOG2);
    assign in_win = (xe >= X_LO) && (xe < X_HI) && (ye >= Y_LO) && (ye < Y_HI);

    // lead tracks "every digit to the left, including this one, is zero"
    always_comb begin
        nib   = 4'd0;
        dv    = 4'd0;
        blank = 1'b0;
        lead  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            nib = playing ? disp[4*(DIGITS-1-i) +: 4] : 4'd0;
            if (k == 11'(i)) begin
                dv    = nib;
                blank = (BLANK_LZ != 0) && (i != DIGITS - 1) && lead && (nib == 4'd0);
            end
            lead = lead && (nib == 4'd0);
        end
    end

    assign rom_row = in_win ? {dv, 4'(dy >> SCALE_LOG2)} : 8'd0;
    assign rom_col = in_win ? 4'(dx >> SCALE_LOG2) : 4'd0;
    assign visible = in_win && !blank && !hide;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            visible_d1 <= 1'b0;
        else
            visible_d1 <= visible;
    end

    assign score_on = rom_data && visible_d1;

endmodule

// File: tb/tb_score_display_multi.sv
// Directed bench for score_display_multi: a default instance plus a 2x-scaled one
// sharing the same stimulus, each fed by a registered pattern ROM model.
module tb_score_display_multi;

    logic        clk = 1'b0;
    logic        reset;
    logic        playing;
    logic [13:0] score;
    logic        score_stb;
    logic        frame_tick;
    logic [9:0]  x, y;
    logic [7:0]  rom_row0, rom_row1;
    logic [3:0]  rom_col0, rom_col1;
    logic        rom_data0, rom_data1;
    logic        score_on0, score_on1;
    logic        busy0, busy1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    function automatic logic pat(input logic [7:0] r, input logic [3:0] c);
        return ~(r[0] ^ c[0]);
    endfunction

    always_ff @(posedge clk) begin
        rom_data0 <= pat(rom_row0, rom_col0);
        rom_data1 <= pat(rom_row1, rom_col1);
    end

    score_display_multi dut0 (
        .clk(clk), .reset(reset), .playing(playing), .score(score),
        .score_stb(score_stb), .frame_tick(frame_tick), .x(x), .y(y),
        .rom_row(rom_row0), .rom_col(rom_col0), .rom_data(rom_data0),
        .score_on(score_on0), .busy(busy0)
    );

    score_display_multi #(.SCALE_LOG2(1)) dut1 (
        .clk(clk), .reset(reset), .playing(playing), .score(score),
        .score_stb(score_stb), .frame_tick(frame_tick), .x(x), .y(y),
        .rom_row(rom_row1), .rom_col(rom_col1), .rom_data(rom_data1),
        .score_on(score_on1), .busy(busy1)
    );

    typedef struct {
        logic [9:0] px;
        logic [9:0] py;
        logic [7:0] row;
        logic [3:0] col;
        logic       vis;
    } pix_t;

    pix_t tbl [12];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pix(input int sel, input int px, input int py, input int row,
                       input int col, input logic vis, input string name);
        @(negedge clk);
        x = 10'(px);
        y = 10'(py);
        #1;
        chk({name, "_row"}, sel ? rom_row1 : rom_row0, row);
        chk({name, "_col"}, sel ? rom_col1 : rom_col0, col);
        @(negedge clk);
        chk({name, "_on"}, sel ? score_on1 : score_on0, int'(vis & pat(8'(row), 4'(col))));
    endtask

    task automatic convert(input int v);
        int n;
        @(negedge clk);
        score     = 14'(v);
        score_stb = 1'b1;
        @(negedge clk);
        score_stb = 1'b0;
        n = 0;
        while ((busy0 || busy1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("conv_done", int'(busy0 | busy1), 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int row_before;
        int busy_seen;
        logic hidden;

        tbl[0]  = '{10'd340,  10'd325, 8'd5,  4'd4,  1'b0};
        tbl[1]  = '{10'd352,  10'd320, 8'd16, 4'd0,  1'b1};
        tbl[2]  = '{10'd368,  10'd330, 8'd42, 4'd0,  1'b1};
        tbl[3]  = '{10'd384,  10'd335, 8'd63, 4'd0,  1'b1};
        tbl[4]  = '{10'd391,  10'd321, 8'd49, 4'd7,  1'b1};
        tbl[5]  = '{10'd399,  10'd320, 8'd48, 4'd15, 1'b1};
        tbl[6]  = '{10'd400,  10'd320, 8'd0,  4'd0,  1'b0};
        tbl[7]  = '{10'd335,  10'd320, 8'd0,  4'd0,  1'b0};
        tbl[8]  = '{10'd360,  10'd336, 8'd0,  4'd0,  1'b0};
        tbl[9]  = '{10'd360,  10'd319, 8'd0,  4'd0,  1'b0};
        tbl[10] = '{10'd0,    10'd0,   8'd0,  4'd0,  1'b0};
        tbl[11] = '{10'd1023, 10'd1023, 8'd0, 4'd0,  1'b0};

        // reset held with strobe active and pixel in the lit last digit
        reset      = 1'b0;
        playing    = 1'b1;
        score      = 14'd5;
        score_stb  = 1'b1;
        frame_tick = 1'b0;
        x          = 10'd384;
        y          = 10'd320;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_busy", busy0, 0);
            chk("rst_on", score_on0, 0);
        end
        reset     = 1'b1;
        score_stb = 1'b0;
        busy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy0 || busy1) busy_seen = 1;
        end
        chk("rst_idle_busy", busy_seen, 0);
        pix(0, 340, 320, 0, 4, 1'b0, "rst_d0");
        pix(0, 352, 320, 0, 0, 1'b0, "rst_d1");
        pix(0, 368, 320, 0, 0, 1'b0, "rst_d2");
        pix(0, 384, 320, 0, 0, 1'b1, "rst_d3");

        // 123: busy length and commit edge
        @(negedge clk);
        score     = 14'd123;
        score_stb = 1'b1;
        x         = 10'd384;
        y         = 10'd320;
        @(negedge clk);
        score_stb  = 1'b0;
        cnt        = 0;
        row_before = -1;
        while (busy0 && cnt < 100) begin
            cnt++;
            if (cnt == 15) row_before = rom_row0;
            @(negedge clk);
        end
        chk("busy_len", cnt, 15);
        chk("pre_commit_row", row_before, 0);
        chk("post_commit_row", rom_row0, 48);

        for (int i = 0; i < 12; i++)
            pix(0, tbl[i].px, tbl[i].py, tbl[i].row, tbl[i].col, tbl[i].vis, $sformatf("tbl%0d", i));
        ticks(32);

        // saturation; second saturated value must not restart blinking
        convert(12000);
        pix(0, 340, 320, 144, 4, 1'b1, "sat_9999");
        ticks(4);
        pix(0, 340, 320, 144, 4, 1'b0, "sat_hidden");
        convert(16383);
        pix(0, 340, 320, 144, 4, 1'b0, "sat_no_reload");
        ticks(28);
        pix(0, 340, 320, 144, 4, 1'b1, "sat_steady");
        pix(1, 341, 329, 148, 2, 1'b1, "scl_pix");
        pix(1, 461, 320, 144, 14, 1'b1, "scl_edge");
        pix(1, 464, 320, 0, 0, 1'b0, "scl_out");

        // back-to-back strobes: 5, then 7 and 9 during CONV
        x = 10'd384;
        y = 10'd320;
        @(negedge clk); score = 14'd5; score_stb = 1'b1;
        @(negedge clk); score_stb = 1'b0;
        @(negedge clk); score = 14'd7; score_stb = 1'b1;
        @(negedge clk); score_stb = 1'b0;
        @(negedge clk); score = 14'd9; score_stb = 1'b1;
        @(negedge clk); score_stb = 1'b0;
        repeat (25) @(negedge clk);
        chk("b2b_before", rom_row0, 80);
        @(negedge clk);
        chk("b2b_final", rom_row0, 144);
        chk("b2b_single_extra", busy0, 0);
        ticks(32);

        // blink after 42 -> 43
        convert(42);
        ticks(32);
        convert(43);
        for (int f = 1; f <= 32; f++) begin
            ticks(1);
            hidden = (((32 - f) & 4) != 0);
            pix(0, 384, 320, 48, 0, !hidden, $sformatf("blink_f%0d", f));
        end
        ticks(3);
        pix(0, 384, 320, 48, 0, 1'b1, "blink_steady");
        pix(1, 435, 351, 63, 1, 1'b1, "scl_43");

        // playing low shows a single 0
        playing = 1'b0;
        pix(0, 384, 320, 0, 0, 1'b1, "idle_lsd");
        pix(0, 368, 320, 0, 0, 1'b0, "idle_d2");
        pix(0, 352, 320, 0, 0, 1'b0, "idle_d1");
        playing = 1'b1;
        pix(0, 368, 320, 64, 0, 1'b1, "play_d2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
